// File: rtl/if_fetch_unit.sv
// Instruction fetch producer: PC, req/ready imem handshake, 2-entry skid buffer into IF/ID.
// Head entry visible the cycle after its transfer edge; freeze only blocks pop, never an outstanding request.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] INST_NOP = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_Out,
    output logic [31:0] Inst_Out,
    output logic        out_valid
);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

    state_t      state, state_nxt;
    logic        pending;
    logic [31:0] pc, hold_addr;
    logic [1:0]  occ;
    logic [31:0] pc4_q  [2];
    logic [31:0] inst_q [2];
    logic        br, xfer, push, pop, wr_idx;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = FETCH;
            FETCH:   if (branch_taken && imem_req && !imem_ready) state_nxt = DRAIN;
            DRAIN:   if (xfer) state_nxt = FETCH;
            default: state_nxt = IDLE;
        endcase
    end

    // Once a request is outstanding its address comes from hold_addr, so pc may move freely.
    always_comb begin
        imem_req  = (state == DRAIN) || pending || (state == FETCH && occ <= 2'd1);
        imem_addr = (state == DRAIN || pending) ? hold_addr : pc;
        br        = branch_taken && (state != IDLE);
        xfer      = imem_req && imem_ready;
        push      = (state == FETCH) && xfer && !br;
        pop       = (occ != 2'd0) && !freeze && !br;
        wr_idx    = (occ == 2'd2) || (occ == 2'd1 && !pop);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pending   <= 1'b0;
            hold_addr <= RESET_PC;
            pc        <= RESET_PC;
        end else begin
            pending <= imem_req && !imem_ready;
            if (imem_req && !imem_ready) hold_addr <= imem_addr;
            if (br)        pc <= branch_addr;
            else if (push) pc <= pc + 32'd4;
        end
    end

    // Shift-style buffer: slot 0 is always the head; a push into slot 0 overrides the shift.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            occ <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                pc4_q[i]  <= 32'h0;
                inst_q[i] <= INST_NOP;
            end
        end else if (br) begin
            occ <= 2'd0;
        end else begin
            occ <= occ + {1'b0, push} - {1'b0, pop};
            if (pop) begin
                pc4_q[0]  <= pc4_q[1];
                inst_q[0] <= inst_q[1];
            end
            if (push) begin
                pc4_q[wr_idx]  <= pc + 32'd4;
                inst_q[wr_idx] <= imem_rdata;
            end
        end
    end

    assign out_valid = (occ != 2'd0);
    assign PC_Out    = out_valid ? pc4_q[0]  : 32'h0;
    assign Inst_Out  = out_valid ? inst_q[0] : INST_NOP;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit against a queue-based fetch model.
module tb_if_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        freeze = 1'b0, branch_taken = 1'b0, imem_ready = 1'b1;
    logic [31:0] branch_addr = '0, imem_rdata = '0;
    logic        imem_req, out_valid;
    logic [31:0] imem_addr, PC_Out, Inst_Out;

    if_fetch_unit #(.RESET_PC(32'h0), .INST_NOP(NOP)) dut (
        .CLK(CLK), .RST(RST), .freeze(freeze), .branch_taken(branch_taken),
        .branch_addr(branch_addr), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .PC_Out(PC_Out),
        .Inst_Out(Inst_Out), .out_valid(out_valid)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%h exp=%h", tag, $time, got, exp);
        end
    endtask

    // Reference model: fetched pairs in a queue, plus the one outstanding request (if any).
    logic [63:0] q[$];
    logic [31:0] m_pc, m_out_addr;
    bit          m_started, m_outstanding, m_draining;

    task automatic model_reset();
        q.delete();
        m_pc = 32'h0; m_out_addr = 32'h0;
        m_started = 0; m_outstanding = 0; m_draining = 0;
    endtask

    function automatic bit m_req();
        return m_started && (m_outstanding || q.size() <= 1);
    endfunction

    function automatic logic [31:0] m_addr();
        return m_outstanding ? m_out_addr : m_pc;
    endfunction

    task automatic check_outputs();
        check("imem_req", {31'b0, imem_req}, {31'b0, m_req()});
        if (m_req()) check("imem_addr", imem_addr, m_addr());
        check("out_valid", {31'b0, out_valid}, {31'b0, q.size() != 0});
        check("Inst_Out", Inst_Out, q.size() != 0 ? q[0][31:0]  : NOP);
        check("PC_Out",   PC_Out,   q.size() != 0 ? q[0][63:32] : 32'h0);
    endtask

    task automatic model_step();
        bit          req, xfer;
        logic [31:0] addr;
        req  = m_req();
        addr = m_addr();
        xfer = req && imem_ready;
        if (!m_started) begin
            m_started = 1;
        end else if (branch_taken) begin
            q.delete();
            if (m_draining) begin
                if (xfer) begin m_draining = 0; m_outstanding = 0; end
            end else if (req && !imem_ready) begin
                m_draining = 1; m_outstanding = 1; m_out_addr = addr;
            end else begin
                m_outstanding = 0;
            end
            m_pc = branch_addr;
        end else begin
            if (q.size() != 0 && !freeze) void'(q.pop_front());
            if (xfer) begin
                if (m_draining) m_draining = 0;
                else begin
                    q.push_back({m_pc + 32'd4, imem_rdata});
                    m_pc = m_pc + 32'd4;
                end
                m_outstanding = 0;
            end else if (req) begin
                m_outstanding = 1; m_out_addr = addr;
            end
        end
    endtask

    function automatic logic [31:0] pick_target();
        case ($urandom_range(0, 2))
            0:       return 32'h0000_0100;
            1:       return 32'hFFFF_FFF8;
            default: return {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
        endcase
    endfunction

    initial begin
        int rdy_pct, frz_pct, br_pct;
        model_reset();
        #12;
        check("rst_req", {31'b0, imem_req}, 32'h0);
        check("rst_valid", {31'b0, out_valid}, 32'h0);
        check("rst_inst", Inst_Out, NOP);
        check("rst_pc_out", PC_Out, 32'h0);
        @(negedge CLK);
        RST = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc == 1500) begin
                RST = 1'b0;
                imem_ready = 1'b1;
                #1;
                model_reset();
                check("midrst_req", {31'b0, imem_req}, 32'h0);
                check("midrst_valid", {31'b0, out_valid}, 32'h0);
                check("midrst_inst", Inst_Out, NOP);
                @(negedge CLK);
                RST = 1'b1;
            end
            case ((cyc / 250) % 6)
                0:       begin rdy_pct = 100; frz_pct = 0;  br_pct = 0;  end
                1:       begin rdy_pct = 35;  frz_pct = 0;  br_pct = 0;  end
                2:       begin rdy_pct = 100; frz_pct = 90; br_pct = 0;  end
                3:       begin rdy_pct = 40;  frz_pct = 30; br_pct = 8;  end
                4:       begin rdy_pct = 100; frz_pct = 20; br_pct = 10; end
                default: begin rdy_pct = 60;  frz_pct = 50; br_pct = 5;  end
            endcase
            check_outputs();
            imem_ready   = ($urandom_range(0, 99) < rdy_pct);
            freeze       = ($urandom_range(0, 99) < frz_pct);
            branch_taken = ($urandom_range(0, 99) < br_pct);
            branch_addr  = pick_target();
            imem_rdata   = $urandom;
            model_step();
            @(negedge CLK);
        end
        check_outputs();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
